bist_signature_checker: RTL and testbench
=========================================

Name: bist_signature_checker

Overview:
- Response-side counterpart of the BIST controller: compacts circuit-under-test responses into a MISR while the controller runs a test.
- On BIST_END it compares the signature against a golden value selected by the controller's Poly/Seed choice, then reports PASS/FAIL with a held result flag.
- Sits between the CUT outputs and the top-level BIST status logic.

Parameters:
- WIDTH, 8: response and MISR width, in bits (min 2).
- POLY0, 8'h1D: feedback polynomial taps used when POLY_SEL=0 (x^W implicit).
- POLY1, 8'h2B: feedback taps used when POLY_SEL=1.
- SEED0, 8'h01: MISR load value used when SEED_SEL=0.
- SEED1, 8'hA5: MISR load value used when SEED_SEL=1.
- GOLDEN, 32'h0: four WIDTH-bit golden signatures packed, indexed by {POLY_SEL,SEED_SEL}; slice i = GOLDEN[i*WIDTH +: WIDTH].
- EXP_COUNT, 255: expected number of responses. Used only with the optional feature.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- INIT  in  1  one-cycle pulse that starts or restarts a run and loads the seed.
- POLY_SEL  in  1  polynomial select; sampled only on INIT.
- SEED_SEL  in  1  seed select; sampled only on INIT.
- RESP_VALID  in  1  RESP is valid this cycle.
- RESP  in  WIDTH  CUT response vector.
- BIST_END  in  1  pulse from the controller marking the end of the test.
- SIGNATURE  out  WIDTH  current MISR contents.
- RESULT_VALID  out  1  PASS/FAIL are valid; held.
- PASS  out  1  signature matched.
- FAIL  out  1  signature mismatch or protocol error.
- BUSY  out  1  high in COMPACT and COMPARE.

Behaviour:
- Reset (asynchronous): state=IDLE; SIGNATURE=0; count=0; RESULT_VALID=0; PASS=0; FAIL=0; BUSY=0.
- FSM states: IDLE, COMPACT, COMPARE, DONE.
- IDLE/DONE, INIT=1: MISR<=seed[SEED_SEL]; latch POLY_SEL and SEED_SEL; count<=0; clear RESULT_VALID/PASS/FAIL; go to COMPACT next cycle.
- COMPACT, RESP_VALID=1: MISR<={MISR[W-2:0],1'b0} ^ (MISR[W-1] ? poly : 0) ^ RESP; count++, saturating at 2^16-1.
- COMPACT, BIST_END=1: go to COMPARE. A RESP_VALID in the same cycle is compacted first.
- COMPACT, INIT=1: abort the run and reload the seed, same as INIT from IDLE. INIT takes priority over BIST_END.
- COMPARE (1 cycle): eq = (MISR == golden[{poly_l,seed_l}]). Next cycle: DONE, RESULT_VALID=1, PASS=eq, FAIL=!eq.
- Latency: PASS/FAIL are valid 2 clocks after the BIST_END edge.
- DONE: holds the result and SIGNATURE until INIT or RESET. RESP_VALID and BIST_END are ignored.
- BIST_END in IDLE or DONE: ignored.
- RESP_VALID outside COMPACT: ignored; no MISR change.
- RESET mid-run: immediate return to reset values; no result is produced.
- POLY_SEL/SEED_SEL changes mid-run have no effect; only the values latched on INIT are used.
- BUSY = (state==COMPACT || state==COMPARE).

Optional Feature:
- Macro: BIST_COUNT_CHECK_EN.
- Defined: PASS = eq && (count==EXP_COUNT); FAIL otherwise. This catches truncated or over-long runs.
- Undefined: count logic is removed and PASS depends on the signature only. The EXP_COUNT parameter remains but is unused.

Decomposition:
- Package bist_pkg holds:
  - state enum {IDLE, COMPACT, COMPARE, DONE};
  - default POLY/SEED constants;
  - count width constant CNT_W=16.
- Sub-module bist_misr: parameterized WIDTH; inputs load, seed, en, poly, d; output q. Holds the shift/XOR datapath only.
- The FSM, selection logic and comparator live in the top module.

Test Plan:
- Single step, WIDTH=4, POLY0=4'h3, SEED0=4'h1: INIT, one RESP=4'hF, BIST_END -> SIGNATURE=4'hD. With golden slice 0 = 4'hD, PASS=1 and RESULT_VALID=1 two cycles after BIST_END.
- Feedback path, same config: RESP 4'hA then 4'h0 -> SIGNATURE 4'h8, then 4'h3. With golden 4'h4: FAIL=1, PASS=0.
- Simultaneous events: RESP_VALID with RESP=4'h0 in the same cycle as BIST_END from seed 1 -> that vector is compacted (SIGNATURE=4'h2) before the compare.
- Abort: INIT mid-COMPACT after 3 vectors -> SIGNATURE reloads the seed; RESULT_VALID stays 0; the subsequent clean run passes.
- Async reset: RESET asserted in DONE with PASS=1 -> PASS, FAIL and RESULT_VALID go to 0 without waiting for a clock edge; a BIST_END afterwards is ignored.
- BIST_COUNT_CHECK_EN with EXP_COUNT=3: a run of 2 vectors with a matching signature -> FAIL=1; the same run with 3 vectors and a matching signature -> PASS=1.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response-side signature checker.
//   - state_t  : checker FSM states
//   - DEF_*    : default 8-bit polynomial taps and MISR seeds
//   - CNT_W    : width of the saturating response counter
package bist_pkg;

    localparam int CNT_W = 16;

    localparam logic [7:0] DEF_POLY0 = 8'h1D;
    localparam logic [7:0] DEF_POLY1 = 8'h2B;
    localparam logic [7:0] DEF_SEED0 = 8'h01;
    localparam logic [7:0] DEF_SEED1 = 8'hA5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register datapath.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears q)
//   load, seed : load seed into the register (wins over en)
//   en, d      : compact response d this cycle
//   poly       : feedback taps (x^WIDTH implicit)
//   q          : register contents
module bist_misr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic [WIDTH-1:0] poly,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_nxt;

    // Shift left; the bit falling off the top folds back through the taps.
    assign q_nxt = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? poly : '0) ^ d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (en) begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/bist_signature_checker.sv
// BIST response checker: compacts CUT responses into a MISR during a run and,
// at the end of the test, compares the signature with a golden value chosen by
// the polynomial/seed selection latched at INIT. The result is held until the
// next INIT or reset.
//
// Optional build macro: BIST_COUNT_CHECK_EN
//   defined   : PASS also requires exactly EXP_COUNT compacted responses
//   undefined : PASS depends on the signature only (no counter)
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   init                : start/restart pulse, loads the seed
//   poly_sel, seed_sel  : polynomial/seed choice, sampled on init
//   resp_valid, resp    : CUT response strobe and vector
//   bist_end            : end-of-test pulse
//   signature           : current MISR contents
//   result_valid        : pass/fail valid (held)
//   pass, fail          : comparison outcome
//   busy                : run in progress (COMPACT or COMPARE)
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | after reset, waiting for init
// COMPACT | folding responses into the MISR
// COMPARE | one cycle, signature compared with golden value
// DONE    | result and signature held until init
module bist_signature_checker
    import bist_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   POLY0     = WIDTH'(DEF_POLY0),
    parameter logic [WIDTH-1:0]   POLY1     = WIDTH'(DEF_POLY1),
    parameter logic [WIDTH-1:0]   SEED0     = WIDTH'(DEF_SEED0),
    parameter logic [WIDTH-1:0]   SEED1     = WIDTH'(DEF_SEED1),
    parameter logic [4*WIDTH-1:0] GOLDEN    = '0,
    parameter int                 EXP_COUNT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             poly_sel,
    input  logic             seed_sel,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
    input  logic             bist_end,
    output logic [WIDTH-1:0] signature,
    output logic             result_valid,
    output logic             pass,
    output logic             fail,
    output logic             busy
);

    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_COUNT);

    state_t           state, state_nxt;
    logic             poly_l, seed_l;
    logic             misr_load, misr_en;
    logic [WIDTH-1:0] seed_cur, poly_cur, golden_cur;
    logic             sig_eq, run_ok;

    // COMPARE is a single fixed cycle, so init is only honoured elsewhere.
    assign misr_load = init && (state != COMPARE);
    assign misr_en   = resp_valid && (state == COMPACT);

    // Seed uses the live select (it is loaded on the init cycle itself);
    // the polynomial uses the value latched at init.
    assign seed_cur = seed_sel ? SEED1 : SEED0;
    assign poly_cur = poly_l   ? POLY1 : POLY0;

    always_comb begin
        golden_cur = '0;
        case ({poly_l, seed_l})
            2'b00:   golden_cur = GOLDEN[0*WIDTH +: WIDTH];
            2'b01:   golden_cur = GOLDEN[1*WIDTH +: WIDTH];
            2'b10:   golden_cur = GOLDEN[2*WIDTH +: WIDTH];
            default: golden_cur = GOLDEN[3*WIDTH +: WIDTH];
        endcase
    end

    bist_misr #(.WIDTH(WIDTH)) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (misr_load),
        .seed  (seed_cur),
        .en    (misr_en),
        .poly  (poly_cur),
        .d     (resp),
        .q     (signature)
    );

    assign sig_eq = (signature == golden_cur);

`ifdef BIST_COUNT_CHECK_EN
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (misr_load) begin
            count <= '0;
        end else if (misr_en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign run_ok = sig_eq && (count == EXP_CNT);
`else
    logic unused_exp_cnt;

    assign unused_exp_cnt = ^EXP_CNT;
    assign run_ok         = sig_eq;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (init) state_nxt = COMPACT;
            end
            COMPACT: begin
                // init restarts the run and outranks bist_end
                if (init)          state_nxt = COMPACT;
                else if (bist_end) state_nxt = COMPARE;
            end
            COMPARE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poly_l       <= 1'b0;
            seed_l       <= 1'b0;
            result_valid <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
        end else if (misr_load) begin
            poly_l       <= poly_sel;
            seed_l       <= seed_sel;
            result_valid <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
        end else if (state == COMPARE) begin
            result_valid <= 1'b1;
            pass         <= run_ok;
            fail         <= !run_ok;
        end
    end

    assign busy = (state == COMPACT) || (state == COMPARE);

endmodule

// File: tb/tb_bist_signature_checker.sv
module tb_bist_signature_checker;

    localparam int          W      = 4;
    localparam logic [15:0] GOLD   = 16'h596D;
    localparam int          EXP_N  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         init = 1'b0;
    logic         poly_sel = 1'b0;
    logic         seed_sel = 1'b0;
    logic         resp_valid = 1'b0;
    logic [W-1:0] resp = '0;
    logic         bist_end = 1'b0;
    logic [W-1:0] signature;
    logic         result_valid, pass, fail, busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    logic [W-1:0] m_sig;
    logic [W-1:0] m_poly;
    int           m_sel;
    int           m_n;

    logic [W-1:0] polys  [2] = '{4'h3, 4'h9};
    logic [W-1:0] seeds  [2] = '{4'h1, 4'hA};
    logic [W-1:0] golds  [4] = '{4'hD, 4'h6, 4'h9, 4'h5};

    bist_signature_checker #(
        .WIDTH     (W),
        .POLY0     (4'h3),
        .POLY1     (4'h9),
        .SEED0     (4'h1),
        .SEED1     (4'hA),
        .GOLDEN    (GOLD),
        .EXP_COUNT (EXP_N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .poly_sel     (poly_sel),
        .seed_sel     (seed_sel),
        .resp_valid   (resp_valid),
        .resp         (resp),
        .bist_end     (bist_end),
        .signature    (signature),
        .result_valid (result_valid),
        .pass         (pass),
        .fail         (fail),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Signature as polynomial arithmetic: multiply by x modulo (x^W + taps), add response.
    function automatic logic [W-1:0] mstep(input logic [W-1:0] s, input logic [W-1:0] p,
                                           input logic [W-1:0] r);
        int v;
        v = int'(s) * 2;
        if (v >= (1 << W)) v = (v - (1 << W)) ^ int'(p);
        return W'(v) ^ r;
    endfunction

    function automatic logic exp_pass(input logic [W-1:0] s, input int sel, input int n);
        logic ok;
        ok = (s == golds[sel]);
`ifdef BIST_COUNT_CHECK_EN
        ok = ok && (n == EXP_N);
`else
        ok = ok && (n >= 0);
`endif
        return ok;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input int p, input int s);
        init = 1'b1; poly_sel = p[0]; seed_sel = s[0];
        tick();
        init = 1'b0;
        // selects wander afterwards; only the latched values may matter
        poly_sel = 1'($urandom); seed_sel = 1'($urandom);
        m_poly = polys[p]; m_sig = seeds[s]; m_sel = p * 2 + s; m_n = 0;
    endtask

    task automatic send(input logic [W-1:0] r);
        resp_valid = 1'b1; resp = r;
        tick();
        resp_valid = 1'b0; resp = W'($urandom);
        m_sig = mstep(m_sig, m_poly, r); m_n++;
    endtask

    task automatic pulse_end();
        bist_end = 1'b1;
        tick();
        bist_end = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        tests_run++;
        if ({signature, result_valid, pass, fail, busy} !== {4'h0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset_state: got sig=%h rv/p/f/b=%b%b%b%b expected 0 0000",
                     signature, result_valid, pass, fail, busy);
        end
        tick(); tick();
        reset = 1'b0;
        resp_valid = 1'b1; resp = 4'h7; bist_end = 1'b1;
        tick();
        resp_valid = 1'b0; bist_end = 1'b0;
        tests_run++;
        if ({signature, result_valid, busy} !== {4'h0, 2'b00}) begin
            tests_failed++;
            $display("FAIL idle_ignore: got sig=%h rv=%b busy=%b expected 0 0 0",
                     signature, result_valid, busy);
        end
    endtask

    task automatic test_single_step();
        logic e;
        do_init(0, 0);
        send(4'hF);
        tests_run++;
        if (signature !== 4'hD || m_sig !== 4'hD) begin
            tests_failed++;
            $display("FAIL single_sig: got %h model %h expected d", signature, m_sig);
        end
        pulse_end();
        tests_run++;
        if ({result_valid, busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL compare_cycle: got rv=%b busy=%b expected rv=0 busy=1", result_valid, busy);
        end
        tick();
        e = exp_pass(m_sig, m_sel, m_n);
        tests_run++;
        if ({result_valid, pass, fail, busy, signature} !== {1'b1, e, !e, 1'b0, 4'hD}) begin
            tests_failed++;
            $display("FAIL single_result: got rv/p/f/b=%b%b%b%b sig=%h expected 1%b%b0 d",
                     result_valid, pass, fail, busy, signature, e, !e);
        end
    endtask

    task automatic test_feedback();
        do_init(0, 0);
        send(4'hA);
        tests_run++;
        if (signature !== 4'h8) begin
            tests_failed++;
            $display("FAIL feedback_1: got %h expected 8", signature);
        end
        send(4'h0);
        tests_run++;
        if (signature !== 4'h3 || m_sig !== 4'h3) begin
            tests_failed++;
            $display("FAIL feedback_2: got %h model %h expected 3", signature, m_sig);
        end
        pulse_end(); tick();
        tests_run++;
        if ({result_valid, pass, fail} !== 3'b101) begin
            tests_failed++;
            $display("FAIL feedback_result: got rv/p/f=%b%b%b expected 101", result_valid, pass, fail);
        end
    endtask

    task automatic test_simultaneous();
        do_init(0, 0);
        resp_valid = 1'b1; resp = 4'h0; bist_end = 1'b1;
        tick();
        resp_valid = 1'b0; bist_end = 1'b0;
        tests_run++;
        if ({signature, busy, result_valid} !== {4'h2, 2'b10}) begin
            tests_failed++;
            $display("FAIL simul_sig: got sig=%h busy=%b rv=%b expected 2 1 0",
                     signature, busy, result_valid);
        end
        tick();
        tests_run++;
        if ({result_valid, pass, fail, signature} !== {3'b101, 4'h2}) begin
            tests_failed++;
            $display("FAIL simul_result: got rv/p/f=%b%b%b sig=%h expected 101 2",
                     result_valid, pass, fail, signature);
        end
        // DONE ignores further responses and end pulses
        resp_valid = 1'b1; resp = 4'hF; bist_end = 1'b1;
        tick(); tick();
        resp_valid = 1'b0; bist_end = 1'b0;
        tests_run++;
        if ({result_valid, pass, fail, busy, signature} !== {4'b1010, 4'h2}) begin
            tests_failed++;
            $display("FAIL done_hold: got rv/p/f/b=%b%b%b%b sig=%h expected 1010 2",
                     result_valid, pass, fail, busy, signature);
        end
    endtask

    task automatic test_abort();
        logic e;
        do_init(1, 1);
        for (int i = 0; i < 3; i++) send(W'($urandom));
        // init with bist_end: init wins
        bist_end = 1'b1;
        do_init(0, 0);
        bist_end = 1'b0;
        tests_run++;
        if ({signature, result_valid, busy} !== {4'h1, 2'b01}) begin
            tests_failed++;
            $display("FAIL abort_reload: got sig=%h rv=%b busy=%b expected 1 0 1",
                     signature, result_valid, busy);
        end
        send(4'hF);
        pulse_end(); tick();
        e = exp_pass(m_sig, m_sel, m_n);
        tests_run++;
        if ({result_valid, pass, fail, signature} !== {1'b1, e, !e, 4'hD}) begin
            tests_failed++;
            $display("FAIL abort_rerun: got rv/p/f=%b%b%b sig=%h expected 1%b%b d",
                     result_valid, pass, fail, signature, e, !e);
        end
    endtask

    task automatic test_async_reset();
        do_init(0, 0);
        send(4'hF);
        pulse_end(); tick();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({result_valid, pass, fail, busy, signature} !== {4'b0000, 4'h0}) begin
            tests_failed++;
            $display("FAIL async_reset: got rv/p/f/b=%b%b%b%b sig=%h expected 0000 0",
                     result_valid, pass, fail, busy, signature);
        end
        #1;
        reset = 1'b0;
        tick();
        pulse_end(); tick();
        tests_run++;
        if ({result_valid, pass, fail, busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL end_after_reset: got rv/p/f/b=%b%b%b%b expected 0000",
                     result_valid, pass, fail, busy);
        end
    endtask

    task automatic test_random();
        logic e;
        int   n;
        for (int run = 0; run < 25; run++) begin
            do_init(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            n = int'($urandom_range(0, 10));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send(W'($urandom));
            end
            pulse_end(); tick();
            e = exp_pass(m_sig, m_sel, m_n);
            tests_run++;
            if ({signature, result_valid, pass, fail, busy} !== {m_sig, 1'b1, e, !e, 1'b0}) begin
                tests_failed++;
                $display("FAIL random_run%0d: got sig=%h rv/p/f/b=%b%b%b%b expected sig=%h 1%b%b0",
                         run, signature, result_valid, pass, fail, busy, m_sig, e, !e);
            end
        end
    endtask

`ifdef BIST_COUNT_CHECK_EN
    task automatic test_count_check();
        logic [W-1:0] s;
        // two vectors steered onto the golden signature
        do_init(0, 0);
        send(4'h0);
        s = mstep(m_sig, m_poly, 4'h0) ^ 4'hD;
        send(s);
        pulse_end(); tick();
        tests_run++;
        if ({signature, pass, fail} !== {4'hD, 2'b01}) begin
            tests_failed++;
            $display("FAIL count_short: got sig=%h p/f=%b%b expected d 01", signature, pass, fail);
        end
        do_init(0, 0);
        send(4'h0); send(4'h0);
        s = mstep(m_sig, m_poly, 4'h0) ^ 4'hD;
        send(s);
        pulse_end(); tick();
        tests_run++;
        if ({signature, pass, fail} !== {4'hD, 2'b10}) begin
            tests_failed++;
            $display("FAIL count_exact: got sig=%h p/f=%b%b expected d 10", signature, pass, fail);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_step();
        test_feedback();
        test_simultaneous();
        test_abort();
        test_async_reset();
        test_random();
`ifdef BIST_COUNT_CHECK_EN
        test_count_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
